// File: rtl/ifu_axi_rd_slave.sv
// AXI4 read-only slave that serves instruction-fetch bursts from a 1-cycle-latency SRAM.
// One burst at a time; beats pass through a read-in-flight stage and a 2-entry output FIFO.
module ifu_axi_rd_slave #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ID_WIDTH   = 4,
  parameter int unsigned            MEM_AW     = 14,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic [1:0]            S_AXI_ARBURST,
  input  logic                  S_AXI_ARLOCK,
  input  logic [3:0]            S_AXI_ARCACHE,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic [3:0]            S_AXI_ARQOS,
  input  logic [3:0]            S_AXI_ARUSER,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]   S_AXI_RID,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic [3:0]            S_AXI_RUSER,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  mem_re_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            rem_q;
  logic                  fixed_q;
  logic                  err_q;
  logic                  issue_done_q;

  // Read issued last cycle: its data is on mem_rdata_i this cycle.
  logic                  pend_q;
  logic                  pend_err_q;
  logic                  pend_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_err_q  [2];
  logic                  fifo_last_q [2];
  logic [1:0]            cnt_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  beat_err;
  logic                  issue;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  fifo_has;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  head_err;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  unused_inputs;

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (offset >> (MEM_AW + 2)) == '0;
  assign beat_err = err_q | ~in_range;

  // Buffered plus in-flight beats never exceed the two FIFO slots.
  assign issue = (state_q == StBurst) && !issue_done_q && ((cnt_q + {1'b0, pend_q}) < 2'd2);

  assign mem_re_o   = issue & ~beat_err;
  assign mem_addr_o = mem_re_o ? offset[MEM_AW+1:2] : '0;

  assign fifo_has  = (cnt_q != 2'd0);
  assign head_err  = fifo_has ? fifo_err_q[rd_ptr_q]  : pend_err_q;
  assign head_last = fifo_has ? fifo_last_q[rd_ptr_q] : pend_last_q;
  assign head_data = fifo_has ? fifo_data_q[rd_ptr_q] : (pend_err_q ? '0 : mem_rdata_i);

  assign S_AXI_ARREADY = rst_n && (state_q == StIdle);
  assign S_AXI_RVALID  = fifo_has | pend_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = S_AXI_RVALID ? head_data : '0;
  assign S_AXI_RRESP   = (S_AXI_RVALID && head_err) ? 2'b10 : 2'b00;
  assign S_AXI_RLAST   = S_AXI_RVALID & head_last;
  assign S_AXI_RUSER   = '0;

  assign ar_hs     = S_AXI_ARREADY & S_AXI_ARVALID;
  assign r_hs      = S_AXI_RVALID & S_AXI_RREADY;
  assign fifo_pop  = fifo_has & S_AXI_RREADY;
  // An arriving beat bypasses the FIFO only when it is the head and is taken at once.
  assign fifo_push = pend_q & ~(~fifo_has & S_AXI_RREADY);

  assign unused_inputs = ^{S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER,
                           offset[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rid_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      fixed_q      <= 1'b0;
      err_q        <= 1'b0;
      issue_done_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_last_q  <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ar_hs) begin
            rid_q        <= S_AXI_ARID;
            addr_q       <= S_AXI_ARADDR;
            rem_q        <= S_AXI_ARLEN;
            fixed_q      <= (S_AXI_ARBURST == 2'b00);
            err_q        <= (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
            issue_done_q <= 1'b0;
            state_q      <= StBurst;
          end
        end
        StBurst: begin
          if (issue) begin
            rem_q <= rem_q - 8'd1;
            if (!fixed_q) addr_q <= addr_q + ADDR_WIDTH'(4);
            if (rem_q == 8'd0) issue_done_q <= 1'b1;
          end
          if (r_hs && head_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      pend_q      <= issue;
      pend_err_q  <= beat_err;
      pend_last_q <= (rem_q == 8'd0);
      cnt_q       <= cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= pend_err_q ? '0 : mem_rdata_i;
      fifo_err_q[wr_ptr_q]  <= pend_err_q;
      fifo_last_q[wr_ptr_q] <= pend_last_q;
    end
  end

endmodule
